// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared encodings for the multi-cycle MIPS controller
// Purpose: opcode values, state encoding and datapath select encodings used by
//          the controller and its wait timer.
// Ports:   none (package).
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   // Encodings are visible on state_dbg, so they are fixed explicitly.
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_MEM_ADDR  = 4'd3,
      ST_MEM_RD    = 4'd4,
      ST_MEM_WB    = 4'd5,
      ST_MEM_WR    = 4'd6,
      ST_EXEC      = 4'd7,
      ST_ALU_WB    = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JUMP      = 4'd10,
      ST_ADDI_EX   = 4'd11,
      ST_ADDI_WB   = 4'd12,
      ST_ERROR     = 4'd13,
      ST_BRANCH_NE = 4'd14
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_ADDI  = 2'b11;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold a memory strobe and wait for mem_ready.
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - controller <-> datapath signal bundle
// Purpose: groups the instruction/flag/handshake inputs and all datapath
//          enables. Optional macro MC_CTRL_BNE_EN adds branch_ne.
// Ports (master = controller view):
//   in : opcode, zero, mem_ready
//   out: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//        reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
//        pc_source, illegal_op, ctrl_error, state_dbg [, branch_ne]
interface multicycle_control_fsm_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2
);
   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                reg_dst;
   logic                mem_to_reg;
   logic                reg_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALUOP_W-1:0]  alu_op;
   logic [1:0]          pc_source;
   logic                illegal_op;
   logic                ctrl_error;
   logic [3:0]          state_dbg;
`ifdef MC_CTRL_BNE_EN
   logic                branch_ne;
`endif

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, ctrl_error, state_dbg
`ifdef MC_CTRL_BNE_EN
           , branch_ne
`endif
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, ctrl_error, state_dbg
`ifdef MC_CTRL_BNE_EN
           , branch_ne
`endif
   );

endinterface

// File: rtl/multicycle_control_fsm_wait_timer.sv
// rtl/multicycle_control_fsm_wait_timer.sv - memory wait-state timeout counter
// Purpose: counts cycles spent waiting for mem_ready; expired flags the last
//          permitted waiting cycle.
// Ports: clk, rst_n (async active-low), clear, inc (in); expired (out).
module ctrl_wait_timer #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

   logic [W-1:0] count_q;

   // The count equals TIMEOUT_CYC-1 during the TIMEOUT_CYC-th waiting cycle;
   // a miss on mem_ready in that cycle is the one that brings it to
   // TIMEOUT_CYC, so that cycle is when the controller traps.
   assign expired = (count_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (inc) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS sequencing controller
// Purpose: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, stalls
//          on mem_ready and traps memory timeouts into a sticky ERROR state.
//          Optional macro MC_CTRL_BNE_EN enables bne decoding and branch_ne.
// Ports: clk, rst_n (async active-low); bus (multicycle_control_fsm_if.master).
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 2,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multicycle_control_fsm_if.master bus
);

   state_t state_q, state_d;

   logic [OPCODE_W-1:0] op;
   logic                timer_clr, timer_inc, timer_expired;

   logic                pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0]          alu_src_b, pc_source;
   logic [ALUOP_W-1:0]  alu_op;
   logic                illegal_op, ctrl_error, branch_ne;

   assign op = bus.opcode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op        = ALUOP_W'(ALU_ADD);
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      ctrl_error    = 1'b0;
      branch_ne     = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_FETCH;

         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            // PC+4 and IR load happen only on the cycle the read data is valid.
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end else if (timer_expired) begin
               state_d = ST_ERROR;
            end
         end

         ST_DECODE: begin
            alu_src_b = SRCB_IMM_SL2;
            case (op)
               OP_RTYPE:      state_d = ST_EXEC;
               OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
               OP_BEQ:        state_d = ST_BRANCH;
               OP_J:          state_d = ST_JUMP;
               OP_ADDI:       state_d = ST_ADDI_EX;
`ifdef MC_CTRL_BNE_EN
               OP_BNE:        state_d = ST_BRANCH_NE;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = ST_FETCH;
               end
            endcase
         end

         ST_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         end

         ST_MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
            if (bus.mem_ready)  state_d = ST_MEM_WB;
            else if (timer_expired) state_d = ST_ERROR;
         end

         ST_MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            if (bus.mem_ready)  state_d = ST_FETCH;
            else if (timer_expired) state_d = ST_ERROR;
         end

         ST_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_W'(ALU_FUNCT);
            state_d   = ST_ALU_WB;
         end

         ST_ALU_WB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_d   = ST_FETCH;
         end

         ST_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_W'(ALU_SUB);
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            state_d       = ST_FETCH;
         end

`ifdef MC_CTRL_BNE_EN
         ST_BRANCH_NE: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_W'(ALU_SUB);
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            branch_ne     = 1'b1;
            state_d       = ST_FETCH;
         end
`endif

         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            state_d   = ST_FETCH;
         end

         ST_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_W'(ALU_ADDI);
            state_d   = ST_ADDI_WB;
         end

         ST_ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = ST_FETCH;
         end

         // Only reset leaves ERROR.
         ST_ERROR: ctrl_error = 1'b1;

         default: state_d = ST_IDLE;
      endcase
   end

   // Any state change restarts the count, which covers entry to each wait state.
   assign timer_clr = (state_d != state_q);
   assign timer_inc = is_wait_state(state_q) && !bus.mem_ready;

   ctrl_wait_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clr),
      .inc     (timer_inc),
      .expired (timer_expired)
   );

   assign bus.pc_write      = pc_write;
   assign bus.pc_write_cond = pc_write_cond;
   assign bus.i_or_d        = i_or_d;
   assign bus.mem_read      = mem_read;
   assign bus.mem_write     = mem_write;
   assign bus.ir_write      = ir_write;
   assign bus.reg_dst       = reg_dst;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.reg_write     = reg_write;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_op        = alu_op;
   assign bus.pc_source     = pc_source;
   assign bus.illegal_op    = illegal_op;
   assign bus.ctrl_error    = ctrl_error;
   assign bus.state_dbg     = state_q;
`ifdef MC_CTRL_BNE_EN
   assign bus.branch_ne     = branch_ne;
`else
   logic unused_bne;
   assign unused_bne = branch_ne;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
// Purpose: walks add, lw, sw, beq, j, addi, illegal and bne through the
//          controller, then the timeout boundary, ERROR hold and async reset.
// Ports: none.
module tb_multicycle_control_fsm;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm #(
      .OPCODE_W    (6),
      .ALUOP_W     (2),
      .TIMEOUT_CYC (15)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
   //  mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
   //  pc_source[1:0], illegal_op, ctrl_error}
   localparam logic [17:0] V_IDLE      = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] V_FETCH_RDY = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] V_FETCH_WT  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] V_DECODE    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [17:0] V_DEC_ILL   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
   localparam logic [17:0] V_EXEC      = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
   localparam logic [17:0] V_ALU_WB    = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
   localparam logic [17:0] V_MEM_ADDR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] V_MEM_RD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] V_MEM_WB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
   localparam logic [17:0] V_MEM_WR    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] V_BRANCH    = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
   localparam logic [17:0] V_JUMP      = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
   localparam logic [17:0] V_ADDI_EX   = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
   localparam logic [17:0] V_ADDI_WB   = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
   localparam logic [17:0] V_ERROR     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

   function automatic logic [17:0] outs();
      return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
              bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
              bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
              bus.pc_source, bus.illegal_op, bus.ctrl_error};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive mem_ready on the falling edge, then sample the cycle's state and
   // outputs (Mealy outputs included) well before the next rising edge.
   task automatic step(input logic ready, input logic [3:0] st,
                       input logic [17:0] ov, input string tag);
      @(negedge clk);
      bus.mem_ready = ready;
      #1;
      chk({tag, "/state"}, 32'(bus.state_dbg), 32'(st));
      chk({tag, "/outs"}, 32'(outs()), 32'(ov));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.opcode    = 6'b000000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset/state", 32'(bus.state_dbg), 32'd0);
      chk("reset/outs", 32'(outs()), 32'(V_IDLE));
      rst_n = 1'b1;

      // R-type add, no waits
      bus.opcode = 6'b000000;
      step(1'b1, 4'd1, V_FETCH_RDY, "add_fetch");
      step(1'b1, 4'd2, V_DECODE,    "add_decode");
      step(1'b1, 4'd7, V_EXEC,      "add_exec");
      step(1'b1, 4'd8, V_ALU_WB,    "add_alu_wb");
      step(1'b1, 4'd1, V_FETCH_RDY, "add_refetch");

      // lw with three wait cycles in MEM_RD
      bus.opcode = 6'b100011;
      step(1'b1, 4'd2, V_DECODE,    "lw_decode");
      step(1'b1, 4'd3, V_MEM_ADDR,  "lw_mem_addr");
      step(1'b0, 4'd4, V_MEM_RD,    "lw_rd_wait1");
      step(1'b0, 4'd4, V_MEM_RD,    "lw_rd_wait2");
      step(1'b0, 4'd4, V_MEM_RD,    "lw_rd_wait3");
      step(1'b1, 4'd4, V_MEM_RD,    "lw_rd_done");
      step(1'b1, 4'd5, V_MEM_WB,    "lw_mem_wb");
      step(1'b1, 4'd1, V_FETCH_RDY, "lw_refetch");

      // beq
      bus.opcode = 6'b000100;
      step(1'b1, 4'd2, V_DECODE,    "beq_decode");
      step(1'b1, 4'd9, V_BRANCH,    "beq_branch");
      step(1'b1, 4'd1, V_FETCH_RDY, "beq_refetch");

      // j
      bus.opcode = 6'b000010;
      step(1'b1, 4'd2,  V_DECODE,    "j_decode");
      step(1'b1, 4'd10, V_JUMP,      "j_jump");
      step(1'b1, 4'd1,  V_FETCH_RDY, "j_refetch");

      // addi
      bus.opcode = 6'b001000;
      step(1'b1, 4'd2,  V_DECODE,    "addi_decode");
      step(1'b1, 4'd11, V_ADDI_EX,   "addi_ex");
      step(1'b1, 4'd12, V_ADDI_WB,   "addi_wb");
      step(1'b1, 4'd1,  V_FETCH_RDY, "addi_refetch");

      // unsupported opcode
      bus.opcode = 6'b111111;
      step(1'b1, 4'd2, V_DEC_ILL,   "ill_decode");
      step(1'b1, 4'd1, V_FETCH_RDY, "ill_refetch");

      // bne: legal only when the optional feature is built in
      bus.opcode = 6'b000101;
`ifdef MC_CTRL_BNE_EN
      step(1'b1, 4'd2,  V_DECODE,    "bne_decode");
      step(1'b1, 4'd14, V_BRANCH,    "bne_branch");
      chk("bne_flag", 32'(bus.branch_ne), 32'd1);
      step(1'b1, 4'd1,  V_FETCH_RDY, "bne_refetch");
`else
      step(1'b1, 4'd2, V_DEC_ILL,   "bne_ill_decode");
      step(1'b1, 4'd1, V_FETCH_RDY, "bne_ill_refetch");
`endif

      // sw with one wait cycle
      bus.opcode = 6'b101011;
      step(1'b1, 4'd2, V_DECODE,    "sw_decode");
      step(1'b1, 4'd3, V_MEM_ADDR,  "sw_mem_addr");
      step(1'b0, 4'd6, V_MEM_WR,    "sw_wr_wait");
      step(1'b1, 4'd6, V_MEM_WR,    "sw_wr_done");
      step(1'b1, 4'd1, V_FETCH_RDY, "sw_refetch");

      // sw abandoned by reset while MEM_WR is waiting
      step(1'b1, 4'd2, V_DECODE,    "sw2_decode");
      step(1'b1, 4'd3, V_MEM_ADDR,  "sw2_mem_addr");
      step(1'b0, 4'd6, V_MEM_WR,    "sw2_wr_wait");
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst/mem_write", 32'(bus.mem_write), 32'd0);
      chk("async_rst/state", 32'(bus.state_dbg), 32'd0);
      chk("async_rst/outs", 32'(outs()), 32'(V_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      // Timeout boundary: ready arrives in the 15th FETCH cycle
      step(1'b0, 4'd1, V_FETCH_WT, "restart_fetch");
      for (int i = 2; i <= 14; i++) step(1'b0, 4'd1, V_FETCH_WT, "fetch_wait");
      step(1'b1, 4'd1, V_FETCH_RDY, "fetch_ready_at_limit");
      bus.opcode = 6'b111111;
      step(1'b1, 4'd2, V_DEC_ILL,   "limit_decode");

      // Timeout: 15 FETCH cycles without ready
      for (int i = 1; i <= 15; i++) step(1'b0, 4'd1, V_FETCH_WT, "to_fetch_wait");
      step(1'b0, 4'd13, V_ERROR, "timeout_error");
      for (int i = 2; i <= 50; i++) step(i[0], 4'd13, V_ERROR, "error_hold");

      #1;
      rst_n = 1'b0;
      #1;
      chk("err_rst/state", 32'(bus.state_dbg), 32'd0);
      chk("err_rst/ctrl_error", 32'(bus.ctrl_error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 4'd1, V_FETCH_RDY, "post_error_fetch");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
